alkqsh: RTL and testbench
=========================

Name: alkqsh

Overview:
- ALK Q-register shifter and ALU shift-in source select. Sits directly upstream of the ALU shift-in/out pad router.
- Produces alu_sin_h, the bit shifted into the ALU result on SHL/SHR.
- Consumes alu_sout_shl_h and alu_sout_shr_h to shift the 32-bit Q register in lockstep with the ALU. This gives double-width shifts for multiply/divide steps.
- Includes an iteration counter that sequences multi-cycle MUL/DIV step loops.

Parameters:
- WIDTH, 32, Q register width.
- CNT_W, 5, step counter width.

Ports:
- clk  input  1  system clock
- reset_h  input  1  asynchronous active-high reset
- alu_shl_en_h  input  1  decoded ALU field: shift left this cycle
- alu_shr_en_h  input  1  decoded ALU field: shift right this cycle
- sin_sel  input  3  shift-in source select (see Behaviour)
- alu_c_h  input  1  ALU carry out
- alu_n_h  input  1  ALU sign (result bit WIDTH-1)
- alu_sout_shl_h  input  1  bit shifted out of ALU on SHL
- alu_sout_shr_h  input  1  bit shifted out of ALU on SHR
- q_ld_h  input  1  parallel load Q
- q_d_h  input  WIDTH  Q load data
- q_shift_en_h  input  1  Q participates in this cycle's shift
- step_start_h  input  1  load step counter
- step_init  input  CNT_W  step iteration count
- alu_sin_h  output  1  shift-in bit to pad router (combinational)
- q_h  output  WIDTH  Q register
- step_busy_h  output  1  step counter nonzero
- step_done_h  output  1  one-cycle pulse on final step

Behaviour:
- Reset (async): q_h=0, counter=0, step_busy_h=0, step_done_h=0. alu_sin_h follows its decode from reset state.
- sin_sel decode for alu_sin_h:
  - 0 ZERO: 0
  - 1 ONE: 1
  - 2 CARRY: alu_c_h
  - 3 SIGN: alu_n_h
  - 4 QLINK: q_h[WIDTH-1] when SHL, q_h[0] when SHR
  - 5 NCARRY: ~alu_c_h (divide quotient bit)
  - 6 ROTL: alu_sout_shl_h when SHL, alu_sout_shr_h when SHR
  - 7 reserved: 0
- Shift direction valid: exactly one of alu_shl_en_h and alu_shr_en_h asserted.
- Neither or both asserted: alu_sin_h=0, no Q shift.
- Q update at posedge clk, priority order:
  - 1. q_ld_h: q <= q_d_h, regardless of shift.
  - 2. q_shift_en_h & valid SHL: q <= {q[WIDTH-2:0], qin}. qin = ~alu_c_h when sin_sel=NCARRY, else alu_sout_shl_h.
  - 3. q_shift_en_h & valid SHR: q <= {alu_sout_shr_h, q[WIDTH-1:1]}.
  - 4. Otherwise hold.
- Latency: alu_sin_h has zero cycles from the select and flag inputs. Q reflects a shift one cycle later.
- Step counter:
  - step_start_h loads step_init, with priority over decrement. Start while busy reloads.
  - Decrements by 1 on each cycle with a Q shift (rule 2 or 3) while counter nonzero.
  - step_busy_h = (counter != 0).
  - step_done_h pulses in the cycle after the counter transitions 1 -> 0.
  - step_start_h with step_init=0: counter stays 0; step_done_h pulses the next cycle.
  - Counter never wraps below 0. Shifts at 0 do not decrement.
- Reset mid-step: counter clears immediately; no done pulse.

Optional Feature:
- Macro: ALK_QSH_STEP_CNT_EN.
- Defined: step counter, step_busy_h and step_done_h implemented as above.
- Undefined: counter logic omitted; step_busy_h and step_done_h tied 0; step_start_h and step_init ignored; Q and alu_sin_h behaviour unchanged.

Decomposition:
- Shared ALK package holds:
  - sin_sel encodings as localparams: SIN_ZERO, SIN_ONE, SIN_CARRY, SIN_SIGN, SIN_QLINK, SIN_NCARRY, SIN_ROTL.
  - CNT_W default.
- One natural sub-module, alkqsh_stepcnt (step counter with done pulse), instantiated under ALK_QSH_STEP_CNT_EN.

Test Plan:
- Reset: assert reset_h mid-operation with q=0xDEADBEEF, counter=7 -> q_h=0 and step_busy_h=0 immediately, no step_done_h.
- Load vs shift: q_ld_h=1, q_d_h=0x12345678, q_shift_en_h=1, SHL -> q_h=0x12345678 next cycle.
- SHR multiply step: q=0x00000003, alu_sout_shr_h=1, SHR, q_shift_en_h=1 -> q_h=0x80000001.
- SHL divide step: q=0x80000000, sin_sel=NCARRY, alu_c_h=0, SHL -> q_h=0x00000001. With sin_sel=QLINK, alu_sin_h=1 before the edge.
- Illegal shift: shl=shr=1, q_shift_en_h=1, sin_sel=ONE -> alu_sin_h=0, q unchanged, counter unchanged.
- Step loop: step_init=3, start, then 3 shift cycles -> busy for 3 cycles, step_done_h single pulse after the third. step_init=0 -> done pulse next cycle.

Source files
------------

// File: rtl/alkqsh_pkg.sv
// Shared ALK Q-shifter definitions: shift-in source encodings, default widths
// and the shift-direction decode used by the Q shifter.
package alkqsh_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 5;
  localparam int unsigned SEL_W     = 3;

  localparam logic [SEL_W-1:0] SIN_ZERO   = 3'd0;
  localparam logic [SEL_W-1:0] SIN_ONE    = 3'd1;
  localparam logic [SEL_W-1:0] SIN_CARRY  = 3'd2;
  localparam logic [SEL_W-1:0] SIN_SIGN   = 3'd3;
  localparam logic [SEL_W-1:0] SIN_QLINK  = 3'd4;
  localparam logic [SEL_W-1:0] SIN_NCARRY = 3'd5;
  localparam logic [SEL_W-1:0] SIN_ROTL   = 3'd6;
  localparam logic [SEL_W-1:0] SIN_RSVD   = 3'd7;

  typedef struct packed {
    logic shl;
    logic shr;
  } shift_dir_t;

  // A direction is only valid when exactly one of the two enables is set.
  function automatic shift_dir_t shift_dir(input logic shl_en, input logic shr_en);
    shift_dir_t d;
    d.shl = shl_en & ~shr_en;
    d.shr = shr_en & ~shl_en;
    return d;
  endfunction

endpackage

// File: rtl/alkqsh_stepcnt.sv
// Step iteration counter for multi-cycle MUL/DIV loops: loadable down-counter
// with a busy flag and a one-cycle done pulse on reaching zero.
module alkqsh_stepcnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic [CNT_W-1:0] init,
  input  logic             dec_h,
  output logic             busy_h,
  output logic             done_h
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      cnt    <= '0;
      busy_h <= 1'b0;
      done_h <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy_h <= (cnt_nxt != '0);
      done_h <= done_nxt;
    end
  end

  // Start wins over decrement; a zero-length start completes immediately.
  always_comb begin
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    if (start_h) begin
      cnt_nxt  = init;
      done_nxt = (init == '0);
    end else if (dec_h && (cnt != '0)) begin
      cnt_nxt  = cnt - CNT_W'(1);
      done_nxt = (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/alkqsh.sv
// ALK Q-register shifter and ALU shift-in source select.
// Optional step counter enabled by defining ALK_QSH_STEP_CNT_EN.
module alkqsh
  import alkqsh_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_h,
  input  logic             alu_shl_en_h,
  input  logic             alu_shr_en_h,
  input  logic [2:0]       sin_sel,
  input  logic             alu_c_h,
  input  logic             alu_n_h,
  input  logic             alu_sout_shl_h,
  input  logic             alu_sout_shr_h,
  input  logic             q_ld_h,
  input  logic [WIDTH-1:0] q_d_h,
  input  logic             q_shift_en_h,
  input  logic             step_start_h,
  input  logic [CNT_W-1:0] step_init,
  output logic             alu_sin_h,
  output logic [WIDTH-1:0] q_h,
  output logic             step_busy_h,
  output logic             step_done_h
);

  shift_dir_t       dir;
  logic             shift_fire;
  logic             qin;
  logic [WIDTH-1:0] q_nxt;

  assign dir        = shift_dir(alu_shl_en_h, alu_shr_en_h);
  assign shift_fire = ~q_ld_h & q_shift_en_h & (dir.shl | dir.shr);
  assign qin        = (sin_sel == SIN_NCARRY) ? ~alu_c_h : alu_sout_shl_h;

  // Shift-in source to the ALU; forced low without a valid direction.
  always_comb begin
    alu_sin_h = 1'b0;
    if (dir.shl || dir.shr) begin
      case (sin_sel)
        SIN_ZERO:   alu_sin_h = 1'b0;
        SIN_ONE:    alu_sin_h = 1'b1;
        SIN_CARRY:  alu_sin_h = alu_c_h;
        SIN_SIGN:   alu_sin_h = alu_n_h;
        SIN_QLINK:  alu_sin_h = dir.shl ? q_h[WIDTH-1] : q_h[0];
        SIN_NCARRY: alu_sin_h = ~alu_c_h;
        SIN_ROTL:   alu_sin_h = dir.shl ? alu_sout_shl_h : alu_sout_shr_h;
        default:    alu_sin_h = 1'b0;
      endcase
    end
  end

  always_comb begin
    q_nxt = q_h;
    if (q_ld_h) begin
      q_nxt = q_d_h;
    end else if (shift_fire && dir.shl) begin
      q_nxt = {q_h[WIDTH-2:0], qin};
    end else if (shift_fire && dir.shr) begin
      q_nxt = {alu_sout_shr_h, q_h[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset_h) begin
    if (reset_h) begin
      q_h <= '0;
    end else begin
      q_h <= q_nxt;
    end
  end

`ifdef ALK_QSH_STEP_CNT_EN
  alkqsh_stepcnt #(
    .CNT_W (CNT_W)
  ) u_stepcnt (
    .clk     (clk),
    .reset_h (reset_h),
    .start_h (step_start_h),
    .init    (step_init),
    .dec_h   (shift_fire),
    .busy_h  (step_busy_h),
    .done_h  (step_done_h)
  );
`else
  logic unused_step;
  assign unused_step = ^{step_start_h, step_init};
  assign step_busy_h = 1'b0;
  assign step_done_h = 1'b0;
`endif

endmodule

// File: tb/tb_alkqsh.sv
// Scoreboard bench for alkqsh: driver queues hand-computed expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_alkqsh;
  import alkqsh_pkg::*;

`ifdef ALK_QSH_STEP_CNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic [31:0] d;
    logic        qse;
    logic        shl;
    logic        shr;
    logic [2:0]  sel;
    logic        c;
    logic        n;
    logic        sol;
    logic        sor;
    logic        st;
    logic [4:0]  init;
  } stim_t;

  typedef struct {
    string       name;
    logic        imm;
    logic        chk_sin;
    logic        exp_sin;
    logic [31:0] exp_q;
    logic        exp_busy;
    logic        exp_done;
  } exp_t;

  logic        clk;
  logic        reset_h;
  logic        alu_shl_en_h;
  logic        alu_shr_en_h;
  logic [2:0]  sin_sel;
  logic        alu_c_h;
  logic        alu_n_h;
  logic        alu_sout_shl_h;
  logic        alu_sout_shr_h;
  logic        q_ld_h;
  logic [31:0] q_d_h;
  logic        q_shift_en_h;
  logic        step_start_h;
  logic [4:0]  step_init;
  logic        alu_sin_h;
  logic [31:0] q_h;
  logic        step_busy_h;
  logic        step_done_h;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  alkqsh dut (
    .clk            (clk),
    .reset_h        (reset_h),
    .alu_shl_en_h   (alu_shl_en_h),
    .alu_shr_en_h   (alu_shr_en_h),
    .sin_sel        (sin_sel),
    .alu_c_h        (alu_c_h),
    .alu_n_h        (alu_n_h),
    .alu_sout_shl_h (alu_sout_shl_h),
    .alu_sout_shr_h (alu_sout_shr_h),
    .q_ld_h         (q_ld_h),
    .q_d_h          (q_d_h),
    .q_shift_en_h   (q_shift_en_h),
    .step_start_h   (step_start_h),
    .step_init      (step_init),
    .alu_sin_h      (alu_sin_h),
    .q_h            (q_h),
    .step_busy_h    (step_busy_h),
    .step_done_h    (step_done_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst, input logic ld, input logic [31:0] d,
                               input logic qse, input logic shl, input logic shr,
                               input logic [2:0] sel, input logic c, input logic n,
                               input logic sol, input logic sor, input logic st,
                               input logic [4:0] init);
    stim_t s;
    s.rst = rst; s.ld = ld; s.d = d; s.qse = qse; s.shl = shl; s.shr = shr;
    s.sel = sel; s.c = c; s.n = n; s.sol = sol; s.sor = sor; s.st = st; s.init = init;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Apply one cycle of stimulus mid-cycle and queue the expected response.
  task automatic drv(input string nm, input logic imm, input stim_t s,
                     input logic cs, input logic es, input logic [31:0] eq,
                     input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #2;
    reset_h        = s.rst;
    q_ld_h         = s.ld;
    q_d_h          = s.d;
    q_shift_en_h   = s.qse;
    alu_shl_en_h   = s.shl;
    alu_shr_en_h   = s.shr;
    sin_sel        = s.sel;
    alu_c_h        = s.c;
    alu_n_h        = s.n;
    alu_sout_shl_h = s.sol;
    alu_sout_shr_h = s.sor;
    step_start_h   = s.st;
    step_init      = s.init;
    e.name     = nm;
    e.imm      = imm;
    e.chk_sin  = cs;
    e.exp_sin  = es;
    e.exp_q    = eq;
    e.exp_busy = eb & CNT_EN;
    e.exp_done = ed & CNT_EN;
    sb.push_back(e);
  endtask

  // Monitor: alu_sin_h is checked before the edge, registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_sin) chk({e.name, "/sin"}, 32'(alu_sin_h), 32'(e.exp_sin));
        if (!e.imm) begin
          @(posedge clk);
          #1;
        end
        chk({e.name, "/q"}, q_h, e.exp_q);
        chk({e.name, "/busy"}, 32'(step_busy_h), 32'(e.exp_busy));
        chk({e.name, "/done"}, 32'(step_done_h), 32'(e.exp_done));
      end
    end
  end

  initial begin
    reset_h = 1'b1; q_ld_h = 1'b0; q_d_h = '0; q_shift_en_h = 1'b0;
    alu_shl_en_h = 1'b0; alu_shr_en_h = 1'b0; sin_sel = SIN_ZERO;
    alu_c_h = 1'b0; alu_n_h = 1'b0; alu_sout_shl_h = 1'b0; alu_sout_shr_h = 1'b0;
    step_start_h = 1'b0; step_init = '0;

    drv("rst0",      1, mk(1,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);
    drv("rel",       0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);
    drv("ld_vs_shl", 0, mk(0,1,32'h12345678,1,1,0,SIN_ONE,0,0,1,0,0,5'd0), 1,1, 32'h12345678,0,0);
    drv("ld3",       0, mk(0,1,32'h3,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h3,0,0);
    drv("shr_mul",   0, mk(0,0,32'h0,1,0,1,SIN_ROTL,0,0,0,1,0,5'd0), 1,1, 32'h80000001,0,0);
    drv("ld_msb",    0, mk(0,1,32'h80000000,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h80000000,0,0);
    drv("qlink_shl", 0, mk(0,0,32'h0,0,1,0,SIN_QLINK,0,0,0,0,0,5'd0), 1,1, 32'h80000000,0,0);
    drv("div_shl",   0, mk(0,0,32'h0,1,1,0,SIN_NCARRY,0,0,0,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("illegal",   0, mk(0,0,32'h0,1,1,1,SIN_ONE,0,0,1,1,0,5'd0), 1,0, 32'h1,0,0);

    // Shift-in decode sweep with Q held at 1.
    drv("carry_shr", 0, mk(0,0,32'h0,0,0,1,SIN_CARRY,1,0,0,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("carry0",    0, mk(0,0,32'h0,0,1,0,SIN_CARRY,0,1,1,1,0,5'd0), 1,0, 32'h1,0,0);
    drv("sign1",     0, mk(0,0,32'h0,0,1,0,SIN_SIGN,0,1,0,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("sign0",     0, mk(0,0,32'h0,0,0,1,SIN_SIGN,1,0,0,0,0,5'd0), 1,0, 32'h1,0,0);
    drv("qlink_shr", 0, mk(0,0,32'h0,0,0,1,SIN_QLINK,0,0,0,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("qlink_shl0",0, mk(0,0,32'h0,0,1,0,SIN_QLINK,0,0,0,0,0,5'd0), 1,0, 32'h1,0,0);
    drv("rotl_shl",  0, mk(0,0,32'h0,0,1,0,SIN_ROTL,0,0,1,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("rotl_shr",  0, mk(0,0,32'h0,0,0,1,SIN_ROTL,0,0,1,0,0,5'd0), 1,0, 32'h1,0,0);
    drv("rsvd",      0, mk(0,0,32'h0,0,1,0,SIN_RSVD,1,1,1,1,0,5'd0), 1,0, 32'h1,0,0);
    drv("no_dir",    0, mk(0,0,32'h0,0,0,0,SIN_ONE,1,1,1,1,0,5'd0), 1,0, 32'h1,0,0);
    drv("ncarry_c1", 0, mk(0,0,32'h0,0,0,1,SIN_NCARRY,1,0,0,0,0,5'd0), 1,0, 32'h1,0,0);
    drv("ncarry_c0", 0, mk(0,0,32'h0,0,0,1,SIN_NCARRY,0,0,0,0,0,5'd0), 1,1, 32'h1,0,0);
    drv("shl_sout",  0, mk(0,0,32'h0,1,1,0,SIN_ZERO,1,0,1,0,0,5'd0), 1,0, 32'h3,0,0);

    // Step loop of three counted shifts, with non-shifting cycles in between.
    drv("st3",       0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,1,5'd3), 1,0, 32'h3,1,0);
    drv("st3_s1",    0, mk(0,0,32'h0,1,0,1,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h1,1,0);
    drv("st3_ill",   0, mk(0,0,32'h0,1,1,1,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h1,1,0);
    drv("st3_hold",  0, mk(0,0,32'h0,0,0,1,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h1,1,0);
    drv("st3_s2",    0, mk(0,0,32'h0,1,0,1,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,1,0);
    drv("st3_s3",    0, mk(0,0,32'h0,1,0,1,SIN_ZERO,0,0,0,1,0,5'd0), 1,0, 32'h80000000,0,1);
    drv("st3_idle",  0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h80000000,0,0);
    drv("shift_at0", 0, mk(0,0,32'h0,1,1,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);
    drv("st0",       0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,1,5'd0), 1,0, 32'h0,0,1);
    drv("st0_idle",  0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);

    // Asynchronous reset in the middle of a step loop.
    drv("mid_ld",    0, mk(0,1,32'hDEADBEEF,0,0,0,SIN_ZERO,0,0,0,0,1,5'd7), 1,0, 32'hDEADBEEF,1,0);
    drv("mid_hold",  0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'hDEADBEEF,1,0);
    drv("mid_rst",   1, mk(1,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);
    drv("mid_rst_e", 0, mk(1,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);
    drv("post_rst",  0, mk(0,0,32'h0,0,0,0,SIN_ZERO,0,0,0,0,0,5'd0), 1,0, 32'h0,0,0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
